uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered UART transmitter: the transmit-side counterpart of `UART_RX`, driving the board `UART_TX` pin from the `Shell` command/response path. A small synchronous FIFO accepts bytes from the shell logic through a valid/ready handshake. A bit-timing state machine serializes each byte as 8N1 LSB-first at `CLKS_PER_BIT` clocks per bit. It sends back-to-back frames while the FIFO holds data, so multi-byte responses need no per-byte flow control.

## Interface
- `CLKS_PER_BIT`, 868 — clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 16 — byte entries; power of two, ≥ 2.
- `i_Clock` input 1 — single clock; all logic on the rising edge.
- `i_Reset` input 1 — asynchronous, active-high reset.
- `i_TX_DV` input 1 — write strobe; a byte is accepted on any rising edge where `i_TX_DV && o_TX_Ready`.
- `i_TX_Byte` input 8 — data to queue; sampled only when accepted.
- `o_TX_Ready` output 1 — FIFO not full (combinational from count).
- `o_TX_Serial` output 1 — serial line; idle high; registered.
- `o_TX_Active` output 1 — high from start-bit entry until stop-bit exit of the last queued frame.
- `o_TX_Done` output 1 — one-cycle pulse on the final cycle of each stop bit.
- `o_FIFO_Count` output $clog2(FIFO_DEPTH)+1 — bytes queued, excluding the byte currently being shifted.

## Operation
- FSM states: IDLE, START, DATA, STOP (PARITY added by the configuration macro).
- IDLE: `o_TX_Serial`=1. If the FIFO is not empty, pop the head into the shift register, go to START, and clear the bit counter.
- START: line 0 for `CLKS_PER_BIT` cycles, then DATA with bit index 0.
- DATA: line = `shift[index]`, LSB first. Each bit lasts `CLKS_PER_BIT` cycles. After index 7, go to STOP.
- STOP: line 1 for `CLKS_PER_BIT` cycles. On the last cycle, pulse `o_TX_Done`. Then:
  - if the FIFO is not empty, pop and go straight to START (no idle gap);
  - otherwise go to IDLE.
- Clock counter: counts 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- FIFO boundary rules:
  - Push when full: ignored (`o_TX_Ready`=0), even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: count unchanged; data order preserved.
  - Push into an empty FIFO while in IDLE: the byte is popped on the next edge.
  - Read/write pointers wrap modulo `FIFO_DEPTH`.
- A byte being shifted has already left the FIFO. A full FIFO therefore plus one in-flight byte gives `FIFO_DEPTH`+1 bytes outstanding.
- Reset values: `o_TX_Serial`=1, `o_TX_Active`=0, `o_TX_Done`=0, `o_FIFO_Count`=0, `o_TX_Ready`=1, FSM=IDLE, pointers=0.
- Reset mid-frame: the line returns high asynchronously, the frame is abandoned, the FIFO is flushed, and no `o_TX_Done` pulse is produced.

## Timing
- Acceptance at edge N into an empty FIFO while IDLE: pop at edge N+1; `o_TX_Serial` falls and `o_TX_Active` rises after edge N+1.
- Frame length: 10×`CLKS_PER_BIT` cycles (11× with parity), measured from the start-bit fall to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the stop bit's last cycle.
- `o_TX_Done` asserts during the last stop-bit cycle; `o_TX_Active` falls on the following edge when no more data is queued.
- `o_FIFO_Count` updates on the edge after each push or pop.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP;
  - line = XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles;
  - frame is 11 bits.
- Undefined: no PARITY state; 8N1 frame of 10 bits.
- The matching `UART_RX` build must use the same setting.

## Structure
- Shared include `uart_defs.vh` (the UART package) holds:
  - FSM state encodings (`UART_S_IDLE`, `UART_S_START`, `UART_S_DATA`, `UART_S_PARITY`, `UART_S_STOP`), shared with `UART_RX`;
  - the default `CLKS_PER_BIT` constant.
- Sub-module `uart_tx_fifo`: synchronous FIFO with push/pop/full/empty/count. The top module contains the FSM, counters and shift register.

## Test plan
- Reset, then idle for 100 cycles → `o_TX_Serial`=1, `o_TX_Ready`=1, `o_FIFO_Count`=0, no `o_TX_Done`.
- `CLKS_PER_BIT`=4, write 8'h37 → line low 4 cycles, then bits 1,1,1,0,1,1,0,0 at 4 cycles each, then high 4 cycles. The loopback `UART_RX` delivers 8'h37 and `o_TX_Done` pulses once.
- Write "g", " ", 8'h0D on consecutive cycles → three contiguous frames, no idle gap. RX receives 8'h67, 8'h20, 8'h0D in order; three `o_TX_Done` pulses.
- `FIFO_DEPTH`=4, hold `i_TX_DV` high for 8 cycles → 5 accepted (1 in flight + 4 queued), `o_TX_Ready`=0 while the count is 4, and exactly 5 bytes are transmitted.
- Assert `i_Reset` during data bit 3 → line high immediately, count 0, no `o_TX_Done`. After release, a new write of 8'hA5 transmits correctly.
- With `UART_TX_PARITY_EN`, write 8'h07 → parity bit 1, 11-bit frame of 44 cycles at `CLKS_PER_BIT`=4.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: FSM state encodings (common with the receiver) and default bit timing.
package uart_tx_buffered_pkg;

   localparam int UART_CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {
      UART_S_IDLE   = 3'd0,
      UART_S_START  = 3'd1,
      UART_S_DATA   = 3'd2,
      UART_S_PARITY = 3'd3,
      UART_S_STOP   = 3'd4
   } uart_state_e;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte write handshake between the shell logic (master) and the buffered UART transmitter (slave).
interface uart_tx_buffered_if;
   logic       i_TX_DV;
   logic [7:0] i_TX_Byte;
   logic       o_TX_Ready;

   modport master (output i_TX_DV, output i_TX_Byte, input o_TX_Ready);
   modport slave  (input i_TX_DV, input i_TX_Byte, output o_TX_Ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read; pushes while full are dropped.
module uart_tx_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          i_Clock,
   input  logic          i_Reset,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge i_Clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1 serializer, LSB first, back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_buffered
   import uart_tx_buffered_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          i_Clock,
   input  logic                          i_Reset,
   uart_tx_buffered_if.slave             tx_if,
   output logic                          o_TX_Serial,
   output logic                          o_TX_Active,
   output logic                          o_TX_Done,
   output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   uart_state_e   state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [2:0]    idx, idx_d;
   logic [7:0]    shift, shift_d;
   logic          serial_d;
   logic          pop, full, empty, cnt_last;
   logic [7:0]    head;

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_Clock   (i_Clock),
      .i_Reset   (i_Reset),
      .push      (tx_if.i_TX_DV),
      .push_data (tx_if.i_TX_Byte),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (o_FIFO_Count)
   );

   assign tx_if.o_TX_Ready = !full;
   assign cnt_last         = (cnt == LAST);
   assign o_TX_Active      = (state != UART_S_IDLE);
   assign o_TX_Done        = (state == UART_S_STOP) && cnt_last;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      shift_d = shift;
      pop     = 1'b0;
      case (state)
         UART_S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               cnt_d   = '0;
               state_d = UART_S_START;
            end
         end
         UART_S_START: begin
            if (cnt_last) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = UART_S_DATA;
            end else cnt_d = cnt + CW'(1);
         end
         UART_S_DATA: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = UART_S_PARITY;
`else
                  state_d = UART_S_STOP;
`endif
               end else idx_d = idx + 3'd1;
            end else cnt_d = cnt + CW'(1);
         end
`ifdef UART_TX_PARITY_EN
         UART_S_PARITY: begin
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = UART_S_STOP;
            end else cnt_d = cnt + CW'(1);
         end
`endif
         UART_S_STOP: begin
            // Chain straight into the next start bit when more data is queued.
            if (cnt_last) begin
               cnt_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = UART_S_START;
               end else state_d = UART_S_IDLE;
            end else cnt_d = cnt + CW'(1);
         end
         default: state_d = UART_S_IDLE;
      endcase

      // Line level is decoded from the next state so the output pin is a flop.
      case (state_d)
         UART_S_START:  serial_d = 1'b0;
         UART_S_DATA:   serial_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
         UART_S_PARITY: serial_d = even_parity(shift_d);
`endif
         default:       serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state       <= UART_S_IDLE;
         cnt         <= '0;
         idx         <= '0;
         shift       <= '0;
         o_TX_Serial <= 1'b1;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         idx         <= idx_d;
         shift       <= shift_d;
         o_TX_Serial <= serial_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered at CLKS_PER_BIT=4, FIFO_DEPTH=4 with a loopback receive monitor.
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   typedef struct packed {
      logic       stop_ok;
      logic       par_ok;
      logic [7:0] data;
   } rx_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       ser, act, done;
   logic [2:0] cnt;

   uart_tx_buffered_if bus ();

   uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .i_Clock      (clk),
      .i_Reset      (rst),
      .tx_if        (bus.slave),
      .o_TX_Serial  (ser),
      .o_TX_Active  (act),
      .o_TX_Done    (done),
      .o_FIFO_Count (cnt)
   );

   always #5 clk = ~clk;

   int   n_pass = 0, n_chk = 0;
   int   done_cnt = 0, cyc = 0;
   rx_t  rx_q[$];
   logic [7:0] exp_q[$];
   int   starts[$];

   function automatic logic exp_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (k == 9 && NB == 11) return ^b;
      return 1'b1;
   endfunction

   // Loopback receiver: samples each bit one cycle after its first falling-edge sample.
   initial begin
      logic busy;
      int   mc, j;
      rx_t  cur;
      busy = 1'b0; mc = 0; cur = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) done_cnt++;
         if (rst !== 1'b0) busy = 1'b0;
         else if (!busy) begin
            if (ser === 1'b0) begin
               busy = 1'b1; mc = 0; cur = '0; cur.par_ok = 1'b1;
               starts.push_back(cyc);
            end
         end else begin
            mc++;
            if (mc % CPB == 1) begin
               j = mc / CPB;
               if (j >= 1 && j <= 8) cur.data[j-1] = ser;
               else if (j == 9 && NB == 11) cur.par_ok = (ser === ^cur.data);
               if (j == NB - 1) begin
                  cur.stop_ok = (ser === 1'b1);
                  rx_q.push_back(cur);
               end
            end
            if (mc == FRAME - 1) busy = 1'b0;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      int bad, d0;
      n_chk++; if (ser !== 1'b1) $display("FAIL reset_serial got %b want 1", ser); else n_pass++;
      n_chk++; if (act !== 1'b0) $display("FAIL reset_active got %b want 0", act); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_chk++; if (cnt !== 3'd0) $display("FAIL reset_count got %0d want 0", cnt); else n_pass++;
      n_chk++; if (bus.o_TX_Ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.o_TX_Ready); else n_pass++;
      rst = 1'b0;
      d0 = done_cnt; bad = 0;
      repeat (100) begin
         step();
         if (ser !== 1'b1 || cnt !== 3'd0 || bus.o_TX_Ready !== 1'b1 || act !== 1'b0) bad++;
      end
      n_chk++; if (bad != 0) $display("FAIL idle_outputs got %0d bad cycles want 0", bad); else n_pass++;
      n_chk++; if (done_cnt != d0) $display("FAIL idle_done got %0d pulses want 0", done_cnt - d0); else n_pass++;
   endtask

   task automatic test_frame_bits(input logic [7:0] b);
      int bad_bit, bad_done, bad_act, d0;
      rx_t r;
      logic [7:0] e;
      exp_q.push_back(b);
      d0 = done_cnt;
      bus.i_TX_DV = 1'b1; bus.i_TX_Byte = b;
      step();
      bus.i_TX_DV = 1'b0;
      n_chk++; if (ser !== 1'b1) $display("FAIL accept_line got %b want 1", ser); else n_pass++;
      n_chk++; if (cnt !== 3'd1) $display("FAIL accept_count got %0d want 1", cnt); else n_pass++;
      bad_bit = 0; bad_done = 0; bad_act = 0;
      for (int i = 0; i < FRAME; i++) begin
         step();
         if (ser !== exp_bit(b, i / CPB)) bad_bit++;
         if (done !== (i == FRAME - 1)) bad_done++;
         if (act !== 1'b1) bad_act++;
      end
      n_chk++; if (bad_bit != 0) $display("FAIL frame_bits_%h got %0d wrong cycles want 0", b, bad_bit); else n_pass++;
      n_chk++; if (bad_done != 0) $display("FAIL frame_done_%h got %0d wrong cycles want 0", b, bad_done); else n_pass++;
      n_chk++; if (bad_act != 0) $display("FAIL frame_active_%h got %0d wrong cycles want 0", b, bad_act); else n_pass++;
      step();
      n_chk++; if (act !== 1'b0 || ser !== 1'b1) $display("FAIL frame_end got act=%b ser=%b want 0/1", act, ser); else n_pass++;
      n_chk++; if (done_cnt - d0 != 1) $display("FAIL frame_done_count got %0d want 1", done_cnt - d0); else n_pass++;
      n_chk++;
      if (rx_q.size() == 0 || exp_q.size() == 0) $display("FAIL frame_rx got %0d frames want 1", rx_q.size());
      else begin
         r = rx_q.pop_front(); e = exp_q.pop_front();
         if (r !== {2'b11, e}) $display("FAIL frame_rx got %h want %h", r, {2'b11, e}); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] msg [3];
      int d0;
      rx_t r;
      logic [7:0] e;
      msg[0] = 8'h67; msg[1] = 8'h20; msg[2] = 8'h0D;
      starts.delete();
      d0 = done_cnt;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(msg[i]);
         bus.i_TX_DV = 1'b1; bus.i_TX_Byte = msg[i];
         step();
      end
      bus.i_TX_DV = 1'b0;
      repeat (3 * FRAME + 10) step();
      n_chk++;
      if (starts.size() != 3) $display("FAIL b2b_starts got %0d want 3", starts.size());
      else if (starts[1] - starts[0] != FRAME || starts[2] - starts[1] != FRAME)
         $display("FAIL b2b_gap got %0d,%0d want %0d", starts[1] - starts[0], starts[2] - starts[1], FRAME);
      else n_pass++;
      n_chk++; if (done_cnt - d0 != 3) $display("FAIL b2b_done got %0d want 3", done_cnt - d0); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (rx_q.size() == 0 || exp_q.size() == 0) $display("FAIL b2b_rx%0d got no frame want one", i);
         else begin
            r = rx_q.pop_front(); e = exp_q.pop_front();
            if (r !== {2'b11, e}) $display("FAIL b2b_rx%0d got %h want %h", i, r, {2'b11, e}); else n_pass++;
         end
      end
   endtask

   task automatic test_fifo_full();
      int exp_cnt [8];
      int bad_rdy, bad_cnt, d0;
      rx_t r;
      logic [7:0] e;
      exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 2; exp_cnt[3] = 3;
      exp_cnt[4] = 4; exp_cnt[5] = 4; exp_cnt[6] = 4; exp_cnt[7] = 4;
      d0 = done_cnt; bad_rdy = 0; bad_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0 && cnt !== 3'(exp_cnt[i-1])) bad_cnt++;
         if (bus.o_TX_Ready !== (i < 5)) bad_rdy++;
         if (i < 5) exp_q.push_back(8'hC0 + 8'(i));
         bus.i_TX_DV = 1'b1; bus.i_TX_Byte = 8'hC0 + 8'(i);
         step();
      end
      bus.i_TX_DV = 1'b0;
      n_chk++; if (bad_rdy != 0) $display("FAIL full_ready got %0d wrong cycles want 0", bad_rdy); else n_pass++;
      n_chk++; if (bad_cnt != 0) $display("FAIL full_count got %0d wrong cycles want 0", bad_cnt); else n_pass++;
      n_chk++; if (cnt !== 3'd4 || bus.o_TX_Ready !== 1'b0) $display("FAIL full_hold got cnt=%0d rdy=%b want 4/0", cnt, bus.o_TX_Ready); else n_pass++;
      repeat (5 * FRAME + 20) step();
      n_chk++; if (done_cnt - d0 != 5) $display("FAIL full_done got %0d want 5", done_cnt - d0); else n_pass++;
      n_chk++; if (rx_q.size() != 5) $display("FAIL full_frames got %0d want 5", rx_q.size()); else n_pass++;
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         r = rx_q.pop_front(); e = exp_q.pop_front();
         n_chk++; if (r !== {2'b11, e}) $display("FAIL full_rx got %h want %h", r, {2'b11, e}); else n_pass++;
      end
      rx_q.delete(); exp_q.delete();
      n_chk++; if (cnt !== 3'd0 || bus.o_TX_Ready !== 1'b1) $display("FAIL full_drain got cnt=%0d rdy=%b want 0/1", cnt, bus.o_TX_Ready); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int d0, bad;
      rx_t r;
      d0 = done_cnt;
      bus.i_TX_DV = 1'b1; bus.i_TX_Byte = 8'h5A; step();
      bus.i_TX_Byte = 8'h3C; step();
      bus.i_TX_Byte = 8'h99; step();
      bus.i_TX_DV = 1'b0;
      repeat (16) step();   // now inside data bit 3 of the 8'h5A frame
      n_chk++; if (cnt !== 3'd2) $display("FAIL midrst_pre_count got %0d want 2", cnt); else n_pass++;
      rst = 1'b1;
      #1;
      n_chk++; if (ser !== 1'b1) $display("FAIL midrst_line got %b want 1", ser); else n_pass++;
      n_chk++; if (cnt !== 3'd0 || act !== 1'b0 || done !== 1'b0) $display("FAIL midrst_state got cnt=%0d act=%b done=%b want 0/0/0", cnt, act, done); else n_pass++;
      repeat (3) step();
      rst = 1'b0;
      bad = 0;
      repeat (FRAME + 5) begin
         step();
         if (ser !== 1'b1) bad++;
      end
      n_chk++; if (bad != 0) $display("FAIL midrst_quiet got %0d low cycles want 0", bad); else n_pass++;
      n_chk++; if (done_cnt != d0 || rx_q.size() != 0) $display("FAIL midrst_abandon got done=%0d rx=%0d want 0/0", done_cnt - d0, rx_q.size()); else n_pass++;
      exp_q.push_back(8'hA5);
      bus.i_TX_DV = 1'b1; bus.i_TX_Byte = 8'hA5; step();
      bus.i_TX_DV = 1'b0;
      repeat (FRAME + 5) step();
      n_chk++; if (done_cnt - d0 != 1) $display("FAIL midrst_after_done got %0d want 1", done_cnt - d0); else n_pass++;
      n_chk++;
      if (rx_q.size() == 0) $display("FAIL midrst_after_rx got no frame want a5");
      else begin
         r = rx_q.pop_front();
         if (r !== {2'b11, exp_q.pop_front()}) $display("FAIL midrst_after_rx got %h want %h", r, {2'b11, 8'hA5}); else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.i_TX_DV = 1'b0;
      bus.i_TX_Byte = 8'h00;
      repeat (3) step();
      test_reset();
      test_frame_bits(8'h37);
`ifdef UART_TX_PARITY_EN
      test_frame_bits(8'h07);
`endif
      test_back_to_back();
      test_fifo_full();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
